// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Pointer width for a power-of-two depth; count needs one more bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.
// Latency: write visible on rd_dat the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only pulses wr_vld for accepted writes.
// Ports: clk, wr_vld/wr_addr/wr_dat (write port), rd_addr -> rd_dat (read port).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_vld,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_dat,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]         rd_dat
);

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock elastic FIFO with occupancy count, thresholds and sticky errors.
// Latency: rd_en to dout one cycle (registered); with SYNC_FIFO_FWFT_EN head word shown combinationally.
// Backpressure: writes rejected while full, reads rejected while empty; rejections set sticky flags.
// Ports: clk, rst (async active-high); wr_en/din write side; rd_en/dout/dout_valid read side;
//        full/empty/almost_full/almost_empty/count status; overflow/underflow sticky, err_clr clears.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       din,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ptr_w(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_dat;

    // Status flags decode the registered count only.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge flags: a simultaneous read does not make room
    // for a write when full, nor does a write feed a read when empty.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_vld  (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (din),
        .rd_addr (rd_ptr_q),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error event in the clearing cycle wins over err_clr.
        overflow_d  = (overflow_q  && !err_clr) || (wr_en && full);
        underflow_d = (underflow_q && !err_clr) || (rd_en && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue is always presented; rd_en acknowledges it.
    assign dout       = rd_dat;
    assign dout_valid = !empty;
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (rd_acc) begin
            dout_d = rd_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF_LVL=6, AE_LVL=2).
// Latency: inputs driven 1 time unit after a rising edge, outputs checked at that same point.
// Backpressure: exercises full/empty rejection and the sticky error flags.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] q [$];
    logic [7:0] exp_d;

    sync_fifo_param #(
        .DATA_W (8),
        .DEPTH  (8),
        .AF_LVL (6),
        .AE_LVL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        din     = 8'h00;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        #2;

        // Reset state
        chk("rst_empty",  32'(empty),        32'd1);
        chk("rst_full",   32'(full),         32'd0);
        chk("rst_count",  32'(count),        32'd0);
        chk("rst_dvalid", 32'(dout_valid),   32'd0);
        chk("rst_ovf",    32'(overflow),     32'd0);
        chk("rst_udf",    32'(underflow),    32'd0);
        chk("rst_ae",     32'(almost_empty), 32'd1);
        chk("rst_af",     32'(almost_full),  32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_dout",   32'(dout),         32'd0);
`endif
        rst = 1'b0;
        step();

`ifdef SYNC_FIFO_FWFT_EN
        // First-word-fall-through: written word shows with no read request.
        wr_en = 1'b1; din = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("fwft_dout",   32'(dout),       32'hA5);
        chk("fwft_dvalid", 32'(dout_valid), 32'd1);
        chk("fwft_count",  32'(count),      32'd1);
        step();
        chk("fwft_hold",   32'(dout),       32'hA5);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fwft_empty",  32'(empty),      32'd1);
        chk("fwft_dvalid0", 32'(dout_valid), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fwft_udf",    32'(underflow),  32'd1);
        chk("fwft_count0", 32'(count),      32'd0);
`else
        // Fill 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 8'h11 + 8'(i);
            step();
            chk("fill_count", 32'(count),        32'(i + 1));
            chk("fill_af",    32'(almost_full),  32'((i + 1) >= 6));
            chk("fill_ae",    32'(almost_empty), 32'((i + 1) <= 2));
            chk("fill_full",  32'(full),         32'((i + 1) == 8));
        end

        // Write while full
        din = 8'h99;
        step();
        wr_en = 1'b0;
        chk("ovf_count",  32'(count),    32'd8);
        chk("ovf_set",    32'(overflow), 32'd1);
        step();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr",    32'(overflow), 32'd0);

        // Drain
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            chk("drain_dout",   32'(dout),       32'(8'h11 + 8'(i)));
            chk("drain_dvalid", 32'(dout_valid), 32'd1);
            chk("drain_count",  32'(count),      32'(7 - i));
        end
        rd_en = 1'b0;
        step();
        chk("drain_dvalid0", 32'(dout_valid), 32'd0);
        chk("drain_hold",    32'(dout),       32'h18);
        chk("drain_empty",   32'(empty),      32'd1);

        // Read while empty
        rd_en = 1'b1;
        step();
        chk("udf_set",    32'(underflow),  32'd1);
        chk("udf_dout",   32'(dout),       32'h18);
        chk("udf_dvalid", 32'(dout_valid), 32'd0);
        chk("udf_count",  32'(count),      32'd0);
        err_clr = 1'b1;
        step();
        chk("udf_prio",   32'(underflow),  32'd1);
        rd_en = 1'b0;
        step();
        err_clr = 1'b0;
        chk("udf_clr",    32'(underflow),  32'd0);

        // Write and read together while empty: write only
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h21;
        step();
        chk("we_count",  32'(count),      32'd1);
        chk("we_udf",    32'(underflow),  32'd1);
        chk("we_dvalid", 32'(dout_valid), 32'd0);
        q.push_back(8'h21);
        rd_en = 1'b0; err_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'h22 + 8'(i);
            step();
            err_clr = 1'b0;
            q.push_back(din);
        end
        chk("fill4_count", 32'(count),     32'd4);
        chk("fill4_udf",   32'(underflow), 32'd0);

        // Steady state: 20 cycles of simultaneous write/read across pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'h30 + 8'(i);
            step();
            exp_d = q.pop_front();
            q.push_back(din);
            chk("ss_dout",   32'(dout),       32'(exp_d));
            chk("ss_dvalid", 32'(dout_valid), 32'd1);
            chk("ss_count",  32'(count),      32'd4);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 8'h50 + 8'(i);
            step();
            q.push_back(din);
        end
        chk("refill_full", 32'(full), 32'd1);

        // Write and read together while full: read only
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        exp_d = q.pop_front();
        chk("wf_dout",  32'(dout),     32'(exp_d));
        chk("wf_count", 32'(count),    32'd7);
        chk("wf_ovf",   32'(overflow), 32'd1);
        chk("wf_full",  32'(full),     32'd0);

        // Mid-stream asynchronous reset
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_count",  32'(count),      32'd0);
        chk("mrst_empty",  32'(empty),      32'd1);
        chk("mrst_ovf",    32'(overflow),   32'd0);
        chk("mrst_dout",   32'(dout),       32'd0);
        chk("mrst_dvalid", 32'(dout_valid), 32'd0);
        rst = 1'b0;
        wr_en = 1'b1; din = 8'h5A;
        step();
        wr_en = 1'b0;
        chk("post_count", 32'(count), 32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("post_dout",   32'(dout),       32'h5A);
        chk("post_dvalid", 32'(dout_valid), 32'd1);
        chk("post_empty",  32'(empty),      32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
